hazard_forward_unit: RTL

Parametrised forwarding and hazard controller for the 5-stage pipelined MIPS core, one instance between the ID/EX/MEM/WB pipeline registers and the operand muxes. It generates independent per-operand ALU and branch-comparator forwarding selects, load-use and branch stall/bubble controls, and a memory-wait freeze with a timeout watchdog for multi-cycle data memory.

---
 rtl/hazard_forward_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding-select, load-use/branch hazard and memory-wait freeze controller for the 5-stage MIPS pipeline.
// Optional define HAZ_PERF_CNT_EN adds saturating stall_cnt/freeze_cnt performance counters.
module hazard_forward_unit #(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_regwrite,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic              exmem_memread,
  input  logic              exmem_memwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic              mem_ack,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        cmp_a_sel,
  output logic [1:0]        cmp_b_sel,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              memwb_bubble,
  output logic              mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
`endif
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERR} mem_state_t;

  mem_state_t     state, state_next;
  logic [WCW-1:0] wait_cnt, wait_cnt_next;

  logic ex_a, ex_b, wb_a, wb_b;
  logic ex_ca, ex_cb, wb_ca, wb_cb;
  logic idex_rd_hit, exmem_rd_hit;
  logic load_use, branch_alu, branch_load, hazard;
  logic memop, freeze;

  // Register 0 is hard-wired, so a zero source never matches a producer.
  always_comb begin
    ex_a  = (idex_rs != '0) && exmem_regwrite && (exmem_rd == idex_rs);
    ex_b  = (idex_rt != '0) && exmem_regwrite && (exmem_rd == idex_rt);
    wb_a  = (idex_rs != '0) && memwb_regwrite && (memwb_rd == idex_rs);
    wb_b  = (idex_rt != '0) && memwb_regwrite && (memwb_rd == idex_rt);
    ex_ca = (ifid_rs != '0) && exmem_regwrite && (exmem_rd == ifid_rs);
    ex_cb = (ifid_rt != '0) && exmem_regwrite && (exmem_rd == ifid_rt);
    wb_ca = (ifid_rs != '0) && memwb_regwrite && (memwb_rd == ifid_rs);
    wb_cb = (ifid_rt != '0) && memwb_regwrite && (memwb_rd == ifid_rt);
  end

  always_comb begin
    idex_rd_hit  = (idex_rd != '0) && ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));
    exmem_rd_hit = (exmem_rd != '0) && ((exmem_rd == ifid_rs) || (exmem_rd == ifid_rt));
    load_use     = idex_memread && idex_rd_hit;
    branch_alu   = id_branch && idex_regwrite && !idex_memread && idex_rd_hit;
    branch_load  = id_branch && exmem_memread && exmem_rd_hit;
    hazard       = load_use || branch_alu || branch_load;
  end

  assign memop  = exmem_memread || exmem_memwrite;
  assign freeze = (state == ST_ERR) || (memop && !mem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // The counter reaching TIMEOUT-1 without an ack means TIMEOUT frozen cycles have elapsed.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      ST_RUN: begin
        if (memop && !mem_ack) begin
          state_next    = ST_WAIT;
          wait_cnt_next = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
          state_next = ST_ERR;
        end else begin
          wait_cnt_next = wait_cnt + WCW'(1);
        end
      end
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_RUN;
    endcase
  end

  // Every output is held low while reset is asserted, independent of the inputs.
  always_comb begin
    fwd_a_sel    = 2'b00;
    fwd_b_sel    = 2'b00;
    cmp_a_sel    = 2'b00;
    cmp_b_sel    = 2'b00;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_freeze  = 1'b0;
    memwb_bubble = 1'b0;
    mem_timeout  = 1'b0;
    if (rst_n) begin
      fwd_a_sel    = ex_a ? 2'b10 : (wb_a ? 2'b01 : 2'b00);
      fwd_b_sel    = ex_b ? 2'b10 : (wb_b ? 2'b01 : 2'b00);
      cmp_a_sel    = ex_ca ? 2'b01 : (wb_ca ? 2'b10 : 2'b00);
      cmp_b_sel    = ex_cb ? 2'b01 : (wb_cb ? 2'b10 : 2'b00);
      pc_stall     = freeze || hazard;
      ifid_stall   = freeze || hazard;
      idex_bubble  = hazard && !freeze;
      pipe_freeze  = freeze;
      memwb_bubble = freeze;
      mem_timeout  = (state == ST_ERR);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (idex_bubble && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (pipe_freeze && (freeze_cnt != '1))
        freeze_cnt <= freeze_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
